riscy_seq_ctrl: RTL and testbench

Parametrised sequence controller for the RISCY core. It owns the program counter, instruction register and phase state machine, and drives every enable and strobe in the datapath. It replaces the fixed four-clock phaser/SC pair with memory-ready handshakes, conditional branching and a halt state. Widths are generic, so the core scales beyond 8-bit data and 7-bit address.

---
 rtl/riscy_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_riscy_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscy_seq_ctrl.sv
// riscy_seq_ctrl: sequence controller for the RISCY core.
// Owns PC, IR and the phase FSM. Every strobe is a registered Moore output:
// the strobes for the next phase are decoded from the next state/IR and
// registered on the same edge as STATE, so they are valid for the whole phase.
//
// Handshakes: ROM_RDY and RAM_RDY are sampled on the rising edge while the
// matching select (ROM_CS or RAM_CS) is high; a high ready on that edge
// completes the access and the select drops on the same edge.
module riscy_seq_ctrl #(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 7,
  parameter  int OPC_W   = 4,
  localparam int INSTR_W = OPC_W + 1 + ADDR_W + DATA_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               ROM_RDY,
  input  logic               RAM_RDY,
  input  logic [3:0]         FLAGS_IN,
  output logic [ADDR_W-1:0]  PC,
  output logic               ROM_CS,
  output logic               ROM_OE,
  output logic [OPC_W-1:0]   IR_OPC,
  output logic               IR_IFLAG,
  output logic [ADDR_W-1:0]  IR_ADDR,
  output logic [DATA_W-1:0]  IR_IMM,
  output logic               RAM_CS,
  output logic               RAM_OE,
  output logic               RAM_WE,
  output logic               RDR_EN,
  output logic               A_EN,
  output logic               B_EN,
  output logic               ALU_EN,
  output logic               ALU_OE,
  output logic               PDR_EN,
  output logic               PORT_EN,
  output logic               PORT_RD,
  output logic               MUX_SEL,
  output logic [3:0]         FLAGS,
  output logic [2:0]         STATE,
  output logic               HALTED
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXECUTE = 3'd3,
    S_UPDATE  = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [OPC_W-1:0] OP_LDA    = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_LDB    = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_ALU_LO = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_ALU_HI = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_STO    = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(4'h9);
  localparam logic [OPC_W-1:0] OP_JZ     = OPC_W'(4'hA);
  localparam logic [OPC_W-1:0] OP_JC     = OPC_W'(4'hB);
  localparam logic [OPC_W-1:0] OP_IN     = OPC_W'(4'hC);
  localparam logic [OPC_W-1:0] OP_OUT    = OPC_W'(4'hD);
  localparam logic [OPC_W-1:0] OP_DIR    = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT    = OPC_W'(4'hF);

  state_t              state, nxt_state;
  logic [ADDR_W-1:0]   nxt_pc;
  logic [OPC_W-1:0]    nxt_opc;
  logic                nxt_iflag;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [DATA_W-1:0]   nxt_imm;
  logic [3:0]          nxt_flags;
  logic                op_capture;
  logic                is_alu, taken;
  logic                d_rom_cs, d_rom_oe, d_ram_cs, d_ram_oe, d_ram_we, d_rdr_en;
  logic                d_a_en, d_b_en, d_alu_en, d_alu_oe, d_pdr_en, d_port_en, d_port_rd;
  logic                d_mux_sel, d_halted;

  assign is_alu = (IR_OPC >= OP_ALU_LO) && (IR_OPC <= OP_ALU_HI);
  assign taken  = (IR_OPC == OP_JMP) || ((IR_OPC == OP_JZ) && FLAGS[0]) ||
                  ((IR_OPC == OP_JC) && FLAGS[3]);
  assign STATE  = state;

  // Phase sequencing, IR load, flag capture and PC update.
  always_comb begin
    nxt_state  = state;
    nxt_pc     = PC;
    nxt_opc    = IR_OPC;
    nxt_iflag  = IR_IFLAG;
    nxt_addr   = IR_ADDR;
    nxt_imm    = IR_IMM;
    nxt_flags  = FLAGS;
    op_capture = 1'b0;
    case (state)
      S_FETCH: begin
        if (ROM_CS && ROM_RDY) begin
          {nxt_opc, nxt_iflag, nxt_addr, nxt_imm} = INSTR;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!IR_IFLAG && ((IR_OPC <= OP_ALU_HI) || (IR_OPC == OP_IN)))
          nxt_state = S_OPERAND;
        else
          nxt_state = S_EXECUTE;
      end
      S_OPERAND: begin
        // RAM read completes first; the following cycle latches it into RDR.
        if (RDR_EN)
          nxt_state = S_EXECUTE;
        else if (RAM_RDY)
          op_capture = 1'b1;
      end
      S_EXECUTE: begin
        if (is_alu)
          nxt_flags = FLAGS_IN;
        if (IR_OPC == OP_HLT)
          nxt_state = S_HALT;
        else if ((IR_OPC != OP_STO) || RAM_RDY)
          nxt_state = S_UPDATE;
      end
      S_UPDATE: begin
        nxt_pc    = taken ? IR_ADDR : PC + ADDR_W'(1);
        nxt_state = S_FETCH;
      end
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Strobe decode for the phase being entered, from next state and next IR.
  always_comb begin
    d_rom_cs  = 1'b0; d_rom_oe  = 1'b0; d_ram_cs  = 1'b0; d_ram_oe = 1'b0;
    d_ram_we  = 1'b0; d_rdr_en  = 1'b0; d_a_en    = 1'b0; d_b_en   = 1'b0;
    d_alu_en  = 1'b0; d_alu_oe  = 1'b0; d_pdr_en  = 1'b0; d_port_en = 1'b0;
    d_port_rd = 1'b0; d_mux_sel = 1'b0; d_halted  = 1'b0;
    case (nxt_state)
      S_FETCH: begin
        d_rom_cs = 1'b1;
        d_rom_oe = 1'b1;
      end
      S_OPERAND: begin
        if (op_capture) begin
          d_rdr_en = 1'b1;
        end else begin
          d_ram_cs = 1'b1;
          d_ram_oe = 1'b1;
        end
      end
      S_EXECUTE: begin
        d_mux_sel = ~nxt_iflag;
        if (nxt_opc == OP_LDA)
          d_a_en = 1'b1;
        else if (nxt_opc == OP_LDB)
          d_b_en = 1'b1;
        else if ((nxt_opc >= OP_ALU_LO) && (nxt_opc <= OP_ALU_HI))
          d_alu_en = 1'b1;
        else if (nxt_opc == OP_STO) begin
          d_alu_oe = 1'b1;
          d_ram_cs = 1'b1;
          d_ram_we = 1'b1;
        end else if (nxt_opc == OP_IN) begin
          d_port_rd = 1'b1;
          d_ram_cs  = 1'b1;
          d_ram_we  = 1'b1;
        end else if (nxt_opc == OP_OUT)
          d_port_en = 1'b1;
        else if (nxt_opc == OP_DIR)
          d_pdr_en = 1'b1;
      end
      S_HALT:  d_halted = 1'b1;
      default: ;
    endcase
  end

  // State, PC, IR, flags and all strobes; reset clears everything at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_FETCH;
      PC      <= '0;
      IR_OPC  <= '0;
      IR_IFLAG <= 1'b0;
      IR_ADDR <= '0;
      IR_IMM  <= '0;
      FLAGS   <= '0;
      ROM_CS  <= 1'b0; ROM_OE  <= 1'b0; RAM_CS  <= 1'b0; RAM_OE  <= 1'b0;
      RAM_WE  <= 1'b0; RDR_EN  <= 1'b0; A_EN    <= 1'b0; B_EN    <= 1'b0;
      ALU_EN  <= 1'b0; ALU_OE  <= 1'b0; PDR_EN  <= 1'b0; PORT_EN <= 1'b0;
      PORT_RD <= 1'b0; MUX_SEL <= 1'b0; HALTED  <= 1'b0;
    end else begin
      state   <= nxt_state;
      PC      <= nxt_pc;
      IR_OPC  <= nxt_opc;
      IR_IFLAG <= nxt_iflag;
      IR_ADDR <= nxt_addr;
      IR_IMM  <= nxt_imm;
      FLAGS   <= nxt_flags;
      ROM_CS  <= d_rom_cs;  ROM_OE  <= d_rom_oe;  RAM_CS  <= d_ram_cs;
      RAM_OE  <= d_ram_oe;  RAM_WE  <= d_ram_we;  RDR_EN  <= d_rdr_en;
      A_EN    <= d_a_en;    B_EN    <= d_b_en;    ALU_EN  <= d_alu_en;
      ALU_OE  <= d_alu_oe;  PDR_EN  <= d_pdr_en;  PORT_EN <= d_port_en;
      PORT_RD <= d_port_rd; MUX_SEL <= d_mux_sel; HALTED  <= d_halted;
    end
  end

endmodule

// File: tb/tb_riscy_seq_ctrl.sv
// Directed bench for riscy_seq_ctrl: table of single-instruction vectors with
// hand-computed results, plus hand-written stall, reset and wide-config cases.
module tb_riscy_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-width DUT ----------------
  logic [19:0] instr;
  logic        rom_rdy, ram_rdy;
  logic [3:0]  flags_in;
  logic [6:0]  pc, ir_addr;
  logic        rom_cs, rom_oe, ir_iflag, ram_cs, ram_oe, ram_we, rdr_en;
  logic        a_en, b_en, alu_en, alu_oe, pdr_en, port_en, port_rd, mux_sel, halted;
  logic [3:0]  ir_opc, flags;
  logic [7:0]  ir_imm;
  logic [2:0]  state;
  logic [19:0] rom [128];
  logic [9:0]  en_vec;

  assign instr  = rom[pc];
  assign en_vec = {mux_sel, ram_we, ram_cs, port_rd, port_en, pdr_en, alu_oe, alu_en, b_en, a_en};

  riscy_seq_ctrl dut (
    .CLK(clk), .RST(rst_n), .INSTR(instr), .ROM_RDY(rom_rdy), .RAM_RDY(ram_rdy),
    .FLAGS_IN(flags_in), .PC(pc), .ROM_CS(rom_cs), .ROM_OE(rom_oe),
    .IR_OPC(ir_opc), .IR_IFLAG(ir_iflag), .IR_ADDR(ir_addr), .IR_IMM(ir_imm),
    .RAM_CS(ram_cs), .RAM_OE(ram_oe), .RAM_WE(ram_we), .RDR_EN(rdr_en),
    .A_EN(a_en), .B_EN(b_en), .ALU_EN(alu_en), .ALU_OE(alu_oe), .PDR_EN(pdr_en),
    .PORT_EN(port_en), .PORT_RD(port_rd), .MUX_SEL(mux_sel), .FLAGS(flags),
    .STATE(state), .HALTED(halted)
  );

  // ---------------- wide DUT (DATA_W=16, ADDR_W=10) ----------------
  logic [30:0] instr16;
  logic        rom_rdy16;
  logic [9:0]  pc16, ir_addr16;
  logic        rom_cs16, rom_oe16, ir_iflag16, ram_cs16, ram_oe16, ram_we16, rdr_en16;
  logic        a_en16, b_en16, alu_en16, alu_oe16, pdr_en16, port_en16, port_rd16;
  logic        mux_sel16, halted16;
  logic [3:0]  ir_opc16, flags16;
  logic [15:0] ir_imm16;
  logic [2:0]  state16;
  logic [30:0] rom16 [1024];

  assign instr16 = rom16[pc16];

  riscy_seq_ctrl #(.DATA_W(16), .ADDR_W(10), .OPC_W(4)) dut16 (
    .CLK(clk), .RST(rst_n), .INSTR(instr16), .ROM_RDY(rom_rdy16), .RAM_RDY(1'b1),
    .FLAGS_IN(4'h0), .PC(pc16), .ROM_CS(rom_cs16), .ROM_OE(rom_oe16),
    .IR_OPC(ir_opc16), .IR_IFLAG(ir_iflag16), .IR_ADDR(ir_addr16), .IR_IMM(ir_imm16),
    .RAM_CS(ram_cs16), .RAM_OE(ram_oe16), .RAM_WE(ram_we16), .RDR_EN(rdr_en16),
    .A_EN(a_en16), .B_EN(b_en16), .ALU_EN(alu_en16), .ALU_OE(alu_oe16), .PDR_EN(pdr_en16),
    .PORT_EN(port_en16), .PORT_RD(port_rd16), .MUX_SEL(mux_sel16), .FLAGS(flags16),
    .STATE(state16), .HALTED(halted16)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One instruction: where it sits, its fields, the stimulus, and the result.
  // en bits: {MUX_SEL,RAM_WE,RAM_CS,PORT_RD,PORT_EN,PDR_EN,ALU_OE,ALU_EN,B_EN,A_EN}
  // sampled in the first EXECUTE cycle; cs counts RAM_CS cycles.
  typedef struct {
    logic [6:0] pc;
    logic [3:0] opc;
    logic       ifl;
    logic [6:0] addr;
    logic [7:0] imm;
    logic [3:0] fin;
    int         wait_c;
    int         cyc;
    logic [9:0] en;
    int         cs;
    int         rdr;
    logic [6:0] npc;
    logic [3:0] fl;
    logic       halt;
  } vec_t;

  vec_t tbl [27];

  // ---------------- driver: run one vector from its FETCH cycle ----------------
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic [9:0] en_cap;
    bit got_ex, done, onehot_ok, ir_ok;
    int n, cs_n, rdr_n;
    tag = $sformatf("v%0d", idx);
    en_cap = '0; got_ex = 0; done = 0; onehot_ok = 1; ir_ok = 0;
    n = 1; cs_n = 0; rdr_n = 0;
    check({tag, "_start_pc"}, 32'(pc), 32'(v.pc));
    rom[v.pc] = {v.opc, v.ifl, v.addr, v.imm};
    flags_in  = v.fin;
    ram_rdy   = (v.wait_c == 0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (state == 3'd0 || state == 3'd5) begin
        done = 1;
        break;
      end
      n++;
      if (ram_cs) cs_n++;
      if (rdr_en) rdr_n++;
      if ($countones({a_en, b_en, alu_en, pdr_en, port_en}) > 1) onehot_ok = 0;
      if (state == 3'd3 && !got_ex) begin
        got_ex = 1;
        en_cap = en_vec;
        ir_ok  = (ir_opc == v.opc) && (ir_iflag == v.ifl) &&
                 (ir_addr == v.addr) && (ir_imm == v.imm);
      end
      ram_rdy = (v.wait_c == 0) || (cs_n > v.wait_c);
    end
    check({tag, "_done"},   32'(done && got_ex), 32'd1);
    check({tag, "_cycles"}, 32'(n), 32'(v.cyc));
    check({tag, "_en"},     32'(en_cap), 32'(v.en));
    check({tag, "_ir"},     32'(ir_ok), 32'd1);
    check({tag, "_ram_cs"}, 32'(cs_n), 32'(v.cs));
    check({tag, "_rdr"},    32'(rdr_n), 32'(v.rdr));
    check({tag, "_onehot"}, 32'(onehot_ok), 32'd1);
    check({tag, "_next_pc"}, 32'(pc), 32'(v.npc));
    check({tag, "_flags"},  32'(flags), 32'(v.fl));
    check({tag, "_halted"}, 32'(halted), 32'(v.halt));
    ram_rdy  = 1'b1;
    flags_in = 4'h0;
  endtask

  task automatic wait16(input logic [2:0] target, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state16 == target) begin
        ok = 1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    logic [3:0] saved_opc;

    //           pc     opc   i  addr   imm    fin  w cyc en      cs rdr npc    fl  h
    tbl[0]  = '{7'h00, 4'h0, 1, 7'h00, 8'h05, 4'h0, 0, 4, 10'h001, 0, 0, 7'h01, 4'h0, 0};
    tbl[1]  = '{7'h01, 4'h1, 1, 7'h00, 8'h03, 4'h0, 0, 4, 10'h002, 0, 0, 7'h02, 4'h0, 0};
    tbl[2]  = '{7'h02, 4'h2, 1, 7'h00, 8'h07, 4'h1, 0, 4, 10'h004, 0, 0, 7'h03, 4'h1, 0};
    tbl[3]  = '{7'h03, 4'h8, 0, 7'h20, 8'h00, 4'h0, 0, 4, 10'h388, 1, 0, 7'h04, 4'h1, 0};
    tbl[4]  = '{7'h04, 4'hA, 1, 7'h40, 8'h00, 4'hF, 0, 4, 10'h000, 0, 0, 7'h40, 4'h1, 0};
    tbl[5]  = '{7'h40, 4'h3, 1, 7'h00, 8'h09, 4'h8, 0, 4, 10'h004, 0, 0, 7'h41, 4'h8, 0};
    tbl[6]  = '{7'h41, 4'hA, 1, 7'h10, 8'h00, 4'hF, 0, 4, 10'h000, 0, 0, 7'h42, 4'h8, 0};
    tbl[7]  = '{7'h42, 4'hB, 1, 7'h7F, 8'h00, 4'h0, 0, 4, 10'h000, 0, 0, 7'h7F, 4'h8, 0};
    tbl[8]  = '{7'h7F, 4'hD, 1, 7'h00, 8'h00, 4'h0, 0, 4, 10'h020, 0, 0, 7'h00, 4'h8, 0};
    tbl[9]  = '{7'h00, 4'hE, 1, 7'h00, 8'h00, 4'h0, 0, 4, 10'h010, 0, 0, 7'h01, 4'h8, 0};
    tbl[10] = '{7'h01, 4'hC, 1, 7'h00, 8'h00, 4'h0, 0, 4, 10'h1C0, 1, 0, 7'h02, 4'h8, 0};
    tbl[11] = '{7'h02, 4'h0, 0, 7'h12, 8'h00, 4'h0, 0, 6, 10'h201, 1, 1, 7'h03, 4'h8, 0};
    tbl[12] = '{7'h03, 4'h7, 0, 7'h05, 8'h00, 4'h6, 0, 6, 10'h204, 1, 1, 7'h04, 4'h6, 0};
    tbl[13] = '{7'h04, 4'h9, 1, 7'h50, 8'h00, 4'hF, 0, 4, 10'h000, 0, 0, 7'h50, 4'h6, 0};
    tbl[14] = '{7'h50, 4'hB, 1, 7'h11, 8'h00, 4'hF, 0, 4, 10'h000, 0, 0, 7'h51, 4'h6, 0};
    tbl[15] = '{7'h51, 4'hD, 0, 7'h00, 8'h00, 4'h0, 0, 4, 10'h220, 0, 0, 7'h52, 4'h6, 0};
    tbl[16] = '{7'h52, 4'h0, 0, 7'h12, 8'h00, 4'h0, 3, 9, 10'h201, 4, 1, 7'h53, 4'h6, 0};
    tbl[17] = '{7'h53, 4'h8, 1, 7'h30, 8'h00, 4'hF, 2, 6, 10'h188, 3, 0, 7'h54, 4'h6, 0};
    tbl[18] = '{7'h54, 4'hC, 0, 7'h33, 8'h00, 4'h0, 0, 6, 10'h3C0, 2, 1, 7'h55, 4'h6, 0};
    tbl[19] = '{7'h55, 4'h9, 1, 7'h7F, 8'h00, 4'h0, 0, 4, 10'h000, 0, 0, 7'h7F, 4'h6, 0};
    tbl[20] = '{7'h7F, 4'h9, 1, 7'h7F, 8'h00, 4'h0, 0, 4, 10'h000, 0, 0, 7'h7F, 4'h6, 0};
    tbl[21] = '{7'h7F, 4'h9, 1, 7'h7F, 8'h00, 4'h0, 0, 4, 10'h000, 0, 0, 7'h7F, 4'h6, 0};
    tbl[22] = '{7'h7F, 4'h9, 1, 7'h20, 8'h00, 4'h0, 0, 4, 10'h000, 0, 0, 7'h20, 4'h6, 0};
    // after reset: LDA #5, LDB #3, ADD, HLT
    tbl[23] = '{7'h00, 4'h0, 1, 7'h00, 8'h05, 4'h0, 0, 4, 10'h001, 0, 0, 7'h01, 4'h0, 0};
    tbl[24] = '{7'h01, 4'h1, 1, 7'h00, 8'h03, 4'h0, 0, 4, 10'h002, 0, 0, 7'h02, 4'h0, 0};
    tbl[25] = '{7'h02, 4'h2, 1, 7'h00, 8'h00, 4'h4, 0, 4, 10'h004, 0, 0, 7'h03, 4'h4, 0};
    tbl[26] = '{7'h03, 4'hF, 1, 7'h00, 8'h00, 4'h0, 0, 3, 10'h000, 0, 0, 7'h03, 4'h4, 1};

    for (int i = 0; i < 128; i++) rom[i] = '0;
    for (int i = 0; i < 1024; i++) rom16[i] = '0;
    rom_rdy = 1'b1; ram_rdy = 1'b1; flags_in = 4'h0; rom_rdy16 = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'({en_vec, rom_cs, rom_oe, ram_oe, rdr_en, halted}), 32'd0);
    check("reset_flags_ir", 32'({flags, ir_opc, ir_addr, ir_imm}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_fetch", 32'({state, rom_cs, rom_oe}), 32'({3'd0, 1'b1, 1'b1}));

    for (int i = 0; i < 22; i++) run_vec(tbl[i], i);

    // ROM stall: 10 cycles without ROM_RDY at PC 0x7F
    saved_opc = ir_opc;
    rom[pc] = {4'hF, 1'b1, 7'h00, 8'h00};
    rom_rdy = 1'b0;
    ok = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (state != 3'd0 || pc != 7'h7F || ir_opc != saved_opc || !rom_cs || !rom_oe) ok = 0;
    end
    check("rom_stall", 32'(ok), 32'd1);
    rom_rdy = 1'b1;
    run_vec(tbl[22], 22);

    // reset while waiting in OPERAND
    rom[7'h20] = {4'h0, 1'b0, 7'h12, 8'h00};
    ram_rdy = 1'b0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (state == 3'd2) begin
        ok = 1;
        break;
      end
    end
    check("operand_reached", 32'({ok, ram_cs, ram_oe}), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobes", 32'({en_vec, rom_cs, rom_oe, ram_oe, rdr_en, halted}), 32'd0);
    check("midrst_state_pc", 32'({state, pc}), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ram_rdy = 1'b1;
    @(negedge clk);
    check("restart_fetch", 32'({state, rom_cs, pc}), 32'({3'd0, 1'b1, 7'h00}));

    // short program ending in HLT
    for (int i = 23; i < 27; i++) run_vec(tbl[i], i);
    ok = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!halted || state != 3'd5 || pc != 7'h03 || en_vec != 10'h0 || rom_cs || ram_oe || rdr_en)
        ok = 0;
    end
    check("halt_hold", 32'(ok), 32'd1);

    // wide configuration: field slicing and PC wrap at 0x3FF
    rom16[10'h000] = {4'h9, 1'b1, 10'h3FF, 16'hBEEF};
    rom16[10'h3FF] = {4'h0, 1'b1, 10'h000, 16'hA5C3};
    check("w16_idle", 32'({state16, pc16, rom_cs16}), 32'({3'd0, 10'h000, 1'b1}));
    rom_rdy16 = 1'b1;
    wait16(3'd3, "w16_exec_jmp");
    check("w16_ir_jmp", 32'({ir_opc16, ir_iflag16, ir_addr16}), 32'({4'h9, 1'b1, 10'h3FF}));
    check("w16_imm_jmp", 32'(ir_imm16), 32'hBEEF);
    wait16(3'd0, "w16_fetch1");
    check("w16_pc_jmp", 32'(pc16), 32'h3FF);
    wait16(3'd3, "w16_exec_lda");
    check("w16_imm_lda", 32'({ir_imm16, a_en16}), 32'({16'hA5C3, 1'b1}));
    wait16(3'd0, "w16_fetch2");
    check("w16_pc_wrap", 32'(pc16), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
